// File: rtl/audio_sample_fetch_if.sv
// Flash reader handshake: word-address request out, 32-bit read word and done pulse back.
interface audio_sample_fetch_if #(
    parameter int ADDR_W = 23
);
    logic              start;
    logic              finish;
    logic [ADDR_W-1:0] flash_addr;
    logic [31:0]       flash_data;

    modport master (
        output start,
        output flash_addr,
        input  finish,
        input  flash_data
    );

    modport slave (
        input  start,
        input  flash_addr,
        output finish,
        output flash_data
    );
endinterface

// File: rtl/audio_sample_fetch.sv
// Fetches 32-bit flash words and plays them as two signed 16-bit samples, one per sample tick.
// Optional macro AUDIO_FETCH_LOOP_EN: wrap at the region ends instead of stopping.
module audio_sample_fetch #(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] END_ADDR = 23'h7FFFF
) (
    input  logic                      clk,
    input  logic                      reset_all,
    input  logic                      sample_tick,
    input  logic                      play,
    input  logic                      dir,
    input  logic                      restart,
    audio_sample_fetch_if.master      bus,
    output logic signed [15:0]        audio_out,
    output logic                      audio_valid,
    output logic                      end_reached
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HALF2,
        ADVANCE,
        STOPPED
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic               half_dir_q, half_dir_d;
    logic signed [15:0] audio_q, audio_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               end_q, end_d;

    function automatic logic signed [15:0] half_sel(input logic [31:0] w, input logic upper);
        return upper ? $signed(w[31:16]) : $signed(w[15:0]);
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        half_dir_d = half_dir_q;
        audio_d    = audio_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;

        if (restart) begin
            addr_d  = dir ? END_ADDR : '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_tick && play) begin
                        state_d = FETCH;
                        start_d = 1'b1;
                    end
                end
                FETCH: begin
                    start_d = 1'b1;
                    if (bus.finish) begin
                        start_d    = 1'b0;
                        word_d     = bus.flash_data;
                        half_dir_d = dir;
                        audio_d    = half_sel(bus.flash_data, dir);
                        valid_d    = 1'b1;
                        state_d    = HALF2;
                    end
                end
                HALF2: begin
                    // Second half comes from the direction captured with the word.
                    if (sample_tick && play) begin
                        audio_d = half_sel(word_q, !half_dir_q);
                        valid_d = 1'b1;
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    state_d = IDLE;
                    if ((!dir && addr_q == END_ADDR) || (dir && addr_q == '0)) begin
                        end_d = 1'b1;
`ifdef AUDIO_FETCH_LOOP_EN
                        addr_d = dir ? END_ADDR : '0;
`else
                        state_d = STOPPED;
`endif
                    end else if (!dir) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        addr_d = addr_q - ADDR_W'(1);
                    end
                end
                STOPPED: begin
                    end_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            half_dir_q <= 1'b0;
            audio_q    <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            half_dir_q <= half_dir_d;
            audio_q    <= audio_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
        end
    end

    assign bus.start      = start_q;
    assign bus.flash_addr = addr_q;
    assign audio_out      = audio_q;
    assign audio_valid    = valid_q;
    assign end_reached    = end_q;

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Directed bench for audio_sample_fetch: vector table for play paths, hand sequences for corner cases.
module tb_audio_sample_fetch;

    logic               clk = 1'b0;
    logic               reset_all;
    logic               sample_tick;
    logic               play;
    logic               dir;
    logic               restart;
    logic signed [15:0] audio_out;
    logic               audio_valid;
    logic               end_reached;

    int n_checks = 0;
    int n_fail   = 0;

    audio_sample_fetch_if #(.ADDR_W(23)) flash_bus ();

    audio_sample_fetch #(.ADDR_W(23), .END_ADDR(23'h7FFFF)) dut (
        .clk         (clk),
        .reset_all   (reset_all),
        .sample_tick (sample_tick),
        .play        (play),
        .dir         (dir),
        .restart     (restart),
        .bus         (flash_bus),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .end_reached (end_reached)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        pl;
        logic        dr;
        logic        rs;
        logic        fin;
        logic [31:0] data;
        logic        e_start;
        logic        e_valid;
        logic [15:0] e_audio;
        logic [22:0] e_addr;
        logic        e_end;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic t, input logic p, input logic d, input logic r,
                                input logic f, input logic [31:0] data, input logic es,
                                input logic ev, input logic [15:0] ea, input logic [22:0] ead,
                                input logic ee);
        vec_t v;
        v.tick = t; v.pl = p; v.dr = d; v.rs = r; v.fin = f; v.data = data;
        v.e_start = es; v.e_valid = ev; v.e_audio = ea; v.e_addr = ead; v.e_end = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic t, input logic r, input logic f, input logic [31:0] d);
        sample_tick = t; restart = r; flash_bus.finish = f; flash_bus.flash_data = d;
        step();
        sample_tick = 1'b0; restart = 1'b0; flash_bus.finish = 1'b0;
    endtask

    task automatic play_word(input logic [31:0] d);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, d);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    initial begin
        int n_valid;
        int n_start_after;

        reset_all = 1'b1; sample_tick = 1'b0; play = 1'b0; dir = 1'b0; restart = 1'b0;
        flash_bus.finish = 1'b0; flash_bus.flash_data = 32'h0;

        vecs[0]  = mk(1,1,0,0,0, 32'h0,         1,0,16'h0000,23'h0,     0);
        vecs[1]  = mk(0,1,0,0,0, 32'h0,         1,0,16'h0000,23'h0,     0);
        vecs[2]  = mk(0,1,0,0,0, 32'h0,         1,0,16'h0000,23'h0,     0);
        vecs[3]  = mk(0,1,0,0,1, 32'hBBBB_AAAA, 0,1,16'hAAAA,23'h0,     0);
        vecs[4]  = mk(0,1,0,0,0, 32'h0,         0,0,16'hAAAA,23'h0,     0);
        vecs[5]  = mk(1,1,0,0,0, 32'h0,         0,1,16'hBBBB,23'h0,     0);
        vecs[6]  = mk(0,1,0,0,0, 32'h0,         0,0,16'hBBBB,23'h1,     0);
        vecs[7]  = mk(0,1,1,1,0, 32'h0,         0,0,16'hBBBB,23'h7FFFF, 0);
        vecs[8]  = mk(1,1,1,0,0, 32'h0,         1,0,16'hBBBB,23'h7FFFF, 0);
        vecs[9]  = mk(0,1,1,0,1, 32'h1234_5678, 0,1,16'h1234,23'h7FFFF, 0);
        vecs[10] = mk(1,1,1,0,0, 32'h0,         0,1,16'h5678,23'h7FFFF, 0);
        vecs[11] = mk(0,1,1,0,0, 32'h0,         0,0,16'h5678,23'h7FFFE, 0);
        vecs[12] = mk(1,1,1,1,0, 32'h0,         0,0,16'h5678,23'h7FFFF, 0);
        vecs[13] = mk(0,1,1,0,0, 32'h0,         0,0,16'h5678,23'h7FFFF, 0);
        vecs[14] = mk(0,1,0,1,0, 32'h0,         0,0,16'h5678,23'h0,     0);

        step();
        step();
        check("rst_start", {31'h0, flash_bus.start}, 32'h0);
        check("rst_addr",  {9'h0, flash_bus.flash_addr}, 32'h0);
        check("rst_audio", {16'h0, audio_out}, 32'h0);
        check("rst_valid", {31'h0, audio_valid}, 32'h0);
        check("rst_end",   {31'h0, end_reached}, 32'h0);
        reset_all = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            sample_tick = vecs[i].tick; play = vecs[i].pl; dir = vecs[i].dr;
            restart = vecs[i].rs; flash_bus.finish = vecs[i].fin; flash_bus.flash_data = vecs[i].data;
            step();
            check($sformatf("v%0d_start", i), {31'h0, flash_bus.start}, {31'h0, vecs[i].e_start});
            check($sformatf("v%0d_valid", i), {31'h0, audio_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_audio", i), {16'h0, audio_out}, {16'h0, vecs[i].e_audio});
            check($sformatf("v%0d_addr", i), {9'h0, flash_bus.flash_addr}, {9'h0, vecs[i].e_addr});
            check($sformatf("v%0d_end", i), {31'h0, end_reached}, {31'h0, vecs[i].e_end});
        end
        sample_tick = 1'b0; restart = 1'b0; flash_bus.finish = 1'b0;

        // Forward boundary: rewind backward to land on the last address, then play forward.
        play = 1'b1; dir = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("bnd_addr_top", {9'h0, flash_bus.flash_addr}, 32'h0007_FFFF);
        dir = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("bnd_start", {31'h0, flash_bus.start}, 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0002_0001);
        check("bnd_half1", {16'h0, audio_out}, 32'h0001);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("bnd_half2", {16'h0, audio_out}, 32'h0002);
        step();
`ifdef AUDIO_FETCH_LOOP_EN
        check("wrap_addr", {9'h0, flash_bus.flash_addr}, 32'h0);
        check("wrap_end_on", {31'h0, end_reached}, 32'h1);
        step();
        check("wrap_end_off", {31'h0, end_reached}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_resume", {31'h0, flash_bus.start}, 32'h1);
`else
        check("stop_addr", {9'h0, flash_bus.flash_addr}, 32'h0007_FFFF);
        check("stop_end", {31'h0, end_reached}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("stop_tick%0d_start", i), {31'h0, flash_bus.start}, 32'h0);
            check($sformatf("stop_tick%0d_end", i), {31'h0, end_reached}, 32'h1);
        end
`endif
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("bnd_restart_end", {31'h0, end_reached}, 32'h0);
        check("bnd_restart_addr", {9'h0, flash_bus.flash_addr}, 32'h0);
        check("bnd_restart_start", {31'h0, flash_bus.start}, 32'h0);

        // Tick drop: two ticks while finish is held off for 10 clocks.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("drop_start", {31'h0, flash_bus.start}, 32'h1);
        n_valid = 0;
        n_start_after = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc((i == 2 || i == 5), 1'b0, (i == 10), 32'h5555_3333);
            if (audio_valid) n_valid++;
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (audio_valid) n_valid++;
            if (flash_bus.start) n_start_after++;
        end
        check("drop_valid_count", n_valid, 32'd1);
        check("drop_no_restart", n_start_after, 32'd0);
        check("drop_audio", {16'h0, audio_out}, 32'h3333);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Restart while a fetch at address 5 is outstanding.
        for (int i = 0; i < 5; i++) play_word(32'h0);
        check("rs_addr5", {9'h0, flash_bus.flash_addr}, 32'h5);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("rs_start_on", {31'h0, flash_bus.start}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("rs_start_off", {31'h0, flash_bus.start}, 32'h0);
        check("rs_addr0", {9'h0, flash_bus.flash_addr}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h7777_6666);
        check("rs_late_finish", {31'h0, audio_valid}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("rs_idle_resume", {31'h0, flash_bus.start}, 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Pause in HALF2.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("pause_half1", {16'h0, audio_out}, 32'hF00D);
        play = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("pause_tick%0d", i), {31'h0, audio_valid}, 32'h0);
            step();
        end
        check("pause_hold", {16'h0, audio_out}, 32'hF00D);
        play = 1'b1;
        step();
        check("pause_notick", {31'h0, audio_valid}, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("pause_resume_valid", {31'h0, audio_valid}, 32'h1);
        check("pause_resume_audio", {16'h0, audio_out}, 32'hCAFE);

        // Asynchronous reset in the middle of a fetch.
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("ar_start_on", {31'h0, flash_bus.start}, 32'h1);
        reset_all = 1'b1;
        #1;
        check("ar_start_off", {31'h0, flash_bus.start}, 32'h0);
        check("ar_audio", {16'h0, audio_out}, 32'h0);
        step();
        reset_all = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_sample_fetch.md
AUDIO_SAMPLE_FETCH -- requirements
Module: audio_sample_fetch

Interface
REQ-001 Parameter: ADDR_W, 23, flash word-address width.
REQ-002 Parameter: END_ADDR, 23'h7FFFF, last word address of the audio region.
REQ-003 The block SHALL have a single clock, clk (input, 1), with every flop on its rising edge.
REQ-004 reset_all (input, 1) SHALL be an asynchronous, active-high reset.
REQ-005 sample_tick (input, 1) SHALL be a one-clk pulse at the audio sample rate.
REQ-006 play (input, 1) SHALL be a level: 1 = run, 0 = paused.
REQ-007 dir (input, 1) SHALL select direction: 0 = forward, 1 = backward.
REQ-008 restart (input, 1) SHALL be a one-clk pulse that rewinds playback.
REQ-009 start (output, 1) SHALL be the read request to the flash reader.
REQ-010 finish (input, 1) SHALL be the one-clk read-done pulse from the flash reader.
REQ-011 flash_addr (output, ADDR_W) SHALL be the current word address.
REQ-012 flash_data (input, 32) SHALL be the read word, valid in the cycle finish=1.
REQ-013 audio_out (output, 16) SHALL carry the signed sample to the codec path.
REQ-014 audio_valid (output, 1) SHALL be a one-clk strobe marking a new audio_out.
REQ-015 end_reached (output, 1) SHALL flag the end-of-region event.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HALF2, ADVANCE and STOPPED.
REQ-017 IDLE: on sample_tick with play=1, the block SHALL go to FETCH; other ticks are ignored.
REQ-018 FETCH: start SHALL be 1 for every cycle in FETCH and 0 in all other states.
REQ-019 FETCH: on finish=1, the block SHALL latch flash_data and go to HALF2.
REQ-020 On that same edge, audio_out SHALL load the first half: [15:0] if dir=0, [31:16] if dir=1.
REQ-021 On that edge audio_valid SHALL pulse, so audio_out and audio_valid update 1 clk after finish.
REQ-022 sample_tick pulses arriving while in FETCH SHALL be dropped, not queued.
REQ-023 HALF2: on sample_tick with play=1, the block SHALL output the other half of the latched word, pulse audio_valid and go to ADVANCE.
REQ-024 Half order SHALL be taken from the dir value latched at finish; a dir change takes effect at the next word.
REQ-025 ADVANCE (one clk): flash_addr SHALL step +1 if dir=0 or -1 if dir=1, then go to IDLE.
REQ-026 Boundary: a forward step from END_ADDR and a backward step from 0 SHALL be resolved by the Configuration rules.
REQ-027 play=0 SHALL NOT abort a fetch in progress; FETCH completes, and the FSM then holds in HALF2 until play=1 and sample_tick are both seen.
REQ-028 restart SHALL have the highest priority in every state and override sample_tick in the same cycle.
REQ-029 On restart, flash_addr SHALL be set to 0 if dir=0 or END_ADDR if dir=1, start SHALL go low on the next edge, any pending finish SHALL be ignored, and the FSM SHALL go to IDLE.
REQ-030 On restart, end_reached SHALL be cleared.
REQ-031 audio_out SHALL hold its last value whenever audio_valid=0.

Reset
REQ-032 Reset SHALL set state to IDLE, flash_addr to 0, audio_out to 0, audio_valid to 0, start to 0, end_reached to 0, and the latched word to 0.
REQ-033 Reset asserted mid-FETCH SHALL drop start immediately, asynchronously.

Configuration
REQ-034 The looping feature SHALL be controlled by the macro AUDIO_FETCH_LOOP_EN.
REQ-035 With AUDIO_FETCH_LOOP_EN defined, a forward step past END_ADDR SHALL wrap to 0 and a backward step past 0 SHALL wrap to END_ADDR.
REQ-036 With AUDIO_FETCH_LOOP_EN defined, end_reached SHALL pulse for 1 clk on the wrap.
REQ-037 Without AUDIO_FETCH_LOOP_EN, the boundary step SHALL leave flash_addr unchanged and go to STOPPED.
REQ-038 In STOPPED, end_reached SHALL be held at 1 and all ticks SHALL be ignored; only restart or reset exits STOPPED.

Verification
REQ-039 The bench SHALL cover forward play:
- Stimulus: addr 0, flash_data 32'hBBBB_AAAA, finish 3 clk after start, two ticks.
- Response: audio_out 16'hAAAA then 16'hBBBB, one audio_valid per half, flash_addr becomes 1.
REQ-040 The bench SHALL cover backward play:
- Stimulus: after restart with dir=1, flash_data 32'h1234_5678.
- Response: flash_addr is 23'h7FFFF, audio_out 16'h1234 then 16'h5678, flash_addr becomes 23'h7FFFE.
REQ-041 The bench SHALL cover the boundary:
- Stimulus: forward play with flash_addr at 23'h7FFFF, run in both builds.
- Response with AUDIO_FETCH_LOOP_EN: addr becomes 0 and end_reached pulses 1 clk.
- Response without it: state is STOPPED, end_reached is held 1, and 5 further ticks produce no start.
REQ-042 The bench SHALL cover tick drop:
- Stimulus: 2 ticks during a FETCH with finish delayed 10 clk.
- Response: exactly one audio_valid after finish, and no second start.
REQ-043 The bench SHALL cover restart mid-FETCH:
- Stimulus: restart asserted while start=1, with addr 5.
- Response: start is 0 next clk, addr is 0, state is IDLE, and a later finish produces no audio_valid.
REQ-044 The bench SHALL cover pause:
- Stimulus: play=0 in HALF2 with 4 ticks.
- Response: no audio_valid; after play=1, the next tick emits the second half.
